// File: rtl/retire_ctrl.sv
// Commit-side controller for the reorder buffer: tracks per-slot completion,
// retires the head, and sequences branch-mispredict recovery and halt.
module retire_ctrl #(
   parameter int ROB_SZ         = 8,
   parameter int RECOVER_CYCLES = 2,
   parameter int XLEN           = 32,
   localparam int IDX           = $clog2(ROB_SZ)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            dispatch_valid,
   input  logic [IDX-1:0]  dispatch_index,
   input  logic            dispatch_is_halt,
   input  logic            complete_valid,
   input  logic [IDX-1:0]  complete_index,
   input  logic            complete_mispredict,
   input  logic [XLEN-1:0] complete_target,
   input  logic [IDX-1:0]  rob_head,
   output logic            move_head,
   output logic [IDX-1:0]  retire_index,
   output logic            undo,
   output logic [IDX-1:0]  undo_index,
   output logic [XLEN-1:0] squash_pc,
   output logic            dispatch_stall,
   output logic            halt,
   output logic [31:0]     retired_count
);

   localparam int CW = $clog2(RECOVER_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_RECOVER,
      ST_HALTED
   } state_t;

   state_t                state;
   logic [CW-1:0]         recover_cnt;
   logic [ROB_SZ-1:0]     valid;
   logic [ROB_SZ-1:0]     done;
   logic [ROB_SZ-1:0]     mispred;
   logic [ROB_SZ-1:0]     is_halt;
   logic [XLEN-1:0]       target [ROB_SZ];

   logic                  in_run;
   logic                  head_ready;
   logic                  retire_halt;
   logic                  dispatch_accept;
   logic                  complete_accept;

   // Commit decisions look only at registered slot state and the ROB head,
   // so a completion can never retire in the cycle it is broadcast.
   always_comb begin
      in_run      = (state == ST_RUN);
      head_ready  = valid[rob_head] & done[rob_head];
      move_head   = in_run & head_ready;
      undo        = move_head & mispred[rob_head];
      retire_halt = move_head & ~mispred[rob_head] & is_halt[rob_head];
      squash_pc   = undo ? target[rob_head] : '0;
   end

   assign retire_index   = rob_head;
   assign undo_index     = rob_head;
   assign dispatch_stall = ~in_run | undo;
   assign halt           = (state == ST_HALTED);

   // The squash clears every slot at the same edge, so dispatch is refused in
   // the undo cycle; dispatch beats a same-cycle completion to its slot.
   always_comb begin
      dispatch_accept = dispatch_valid & in_run & ~undo;
      complete_accept = complete_valid & (state != ST_HALTED)
                        & valid[complete_index]
                        & ~(dispatch_accept && (dispatch_index == complete_index));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_RUN;
         recover_cnt   <= '0;
         valid         <= '0;
         done          <= '0;
         mispred       <= '0;
         is_halt       <= '0;
         retired_count <= '0;
      end else begin
         if (move_head) begin
            retired_count <= retired_count + 32'd1;
         end

         if (complete_accept) begin
            done[complete_index]    <= 1'b1;
            mispred[complete_index] <= complete_mispredict;
         end

         case (state)
            ST_RUN: begin
               if (undo) begin
                  valid       <= '0;
                  recover_cnt <= CW'(RECOVER_CYCLES);
                  state       <= ST_RECOVER;
               end else if (retire_halt) begin
                  state <= ST_HALTED;
               end else if (move_head) begin
                  valid[rob_head] <= 1'b0;
               end
            end
            ST_RECOVER: begin
               if (recover_cnt == CNT_ONE) begin
                  recover_cnt <= '0;
                  state       <= ST_RUN;
               end else begin
                  recover_cnt <= recover_cnt - CNT_ONE;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase

         if (dispatch_accept) begin
            valid[dispatch_index]   <= 1'b1;
            done[dispatch_index]    <= 1'b0;
            mispred[dispatch_index] <= 1'b0;
            is_halt[dispatch_index] <= dispatch_is_halt;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (complete_accept) begin
         target[complete_index] <= complete_target;
      end
   end

endmodule

// File: tb/tb_retire_ctrl.sv
// Self-checking bench for retire_ctrl: a cycle table feeds a scoreboard queue
// of expected commit outputs, followed by a hand-written recovery-length check.
module tb_retire_ctrl;

   localparam int ROB_SZ         = 8;
   localparam int RECOVER_CYCLES = 2;
   localparam int XLEN           = 32;
   localparam int IDX            = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            dispatch_valid;
   logic [IDX-1:0]  dispatch_index;
   logic            dispatch_is_halt;
   logic            complete_valid;
   logic [IDX-1:0]  complete_index;
   logic            complete_mispredict;
   logic [XLEN-1:0] complete_target;
   logic [IDX-1:0]  rob_head;
   logic            move_head;
   logic [IDX-1:0]  retire_index;
   logic            undo;
   logic [IDX-1:0]  undo_index;
   logic [XLEN-1:0] squash_pc;
   logic            dispatch_stall;
   logic            halt;
   logic [31:0]     retired_count;

   always #5 clock = ~clock;

   retire_ctrl #(
      .ROB_SZ(ROB_SZ),
      .RECOVER_CYCLES(RECOVER_CYCLES),
      .XLEN(XLEN)
   ) dut (
      .clock(clock),
      .reset(reset),
      .dispatch_valid(dispatch_valid),
      .dispatch_index(dispatch_index),
      .dispatch_is_halt(dispatch_is_halt),
      .complete_valid(complete_valid),
      .complete_index(complete_index),
      .complete_mispredict(complete_mispredict),
      .complete_target(complete_target),
      .rob_head(rob_head),
      .move_head(move_head),
      .retire_index(retire_index),
      .undo(undo),
      .undo_index(undo_index),
      .squash_pc(squash_pc),
      .dispatch_stall(dispatch_stall),
      .halt(halt),
      .retired_count(retired_count)
   );

   typedef struct {
      logic            mh;
      logic            un;
      logic [XLEN-1:0] spc;
      logic            ds;
      logic            hl;
      logic [31:0]     rc;
      logic [IDX-1:0]  head;
   } exp_t;

   typedef struct {
      logic            rst;
      logic            dv;
      logic [IDX-1:0]  di;
      logic            dh;
      logic            cv;
      logic [IDX-1:0]  ci;
      logic            cm;
      logic [XLEN-1:0] ct;
      logic [IDX-1:0]  head;
      exp_t            e;
   } vec_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_vec    = 0;
   int   n_chk    = 0;
   int   n_miscmp = 0;

   function automatic void addv(input logic rst, input logic dv, input int di,
                                input logic dh, input logic cv, input int ci,
                                input logic cm, input logic [XLEN-1:0] ct,
                                input int head, input logic mh, input logic un,
                                input logic [XLEN-1:0] spc, input logic ds,
                                input logic hl, input int rc);
      vec_t v;
      v.rst    = rst;
      v.dv     = dv;
      v.di     = IDX'(di);
      v.dh     = dh;
      v.cv     = cv;
      v.ci     = IDX'(ci);
      v.cm     = cm;
      v.ct     = ct;
      v.head   = IDX'(head);
      v.e.mh   = mh;
      v.e.un   = un;
      v.e.spc  = spc;
      v.e.ds   = ds;
      v.e.hl   = hl;
      v.e.rc   = 32'(rc);
      v.e.head = IDX'(head);
      vecs.push_back(v);
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_miscmp++;
         $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, req);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset               = v.rst;
      dispatch_valid      = v.dv;
      dispatch_index      = v.di;
      dispatch_is_halt    = v.dh;
      complete_valid      = v.cv;
      complete_index      = v.ci;
      complete_mispredict = v.cm;
      complete_target     = v.ct;
      rob_head            = v.head;
      exp_q.push_back(v.e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_miscmp++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = exp_q.pop_front();
         checkField("move_head",      32'(move_head),      32'(e.mh));
         checkField("undo",           32'(undo),           32'(e.un));
         checkField("squash_pc",      squash_pc,           e.spc);
         checkField("dispatch_stall", 32'(dispatch_stall), 32'(e.ds));
         checkField("halt",           32'(halt),           32'(e.hl));
         checkField("retired_count",  retired_count,       e.rc);
         checkField("retire_index",   32'(retire_index),   32'(e.head));
         checkField("undo_index",     32'(undo_index),     32'(e.head));
      end
      n_vec++;
   endtask

   initial begin
      int stall_cnt;
      int undo_cnt;

      reset               = 1'b1;
      dispatch_valid      = 1'b0;
      dispatch_index      = '0;
      dispatch_is_halt    = 1'b0;
      complete_valid      = 1'b0;
      complete_index      = '0;
      complete_mispredict = 1'b0;
      complete_target     = '0;
      rob_head            = '0;
      repeat (2) @(posedge clock);

      //   rst dv di dh cv ci cm ct            hd  mh un spc           ds hl rc
      // in-order retire, slot 2 never completes
      addv(0, 1, 0, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 1, 2, 0, 1, 1, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 1, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            0,  1, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            1,  1, 0, 0,            0, 0, 1);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 2);
      // mispredict on slot 1, completion to slot 2 during recovery ignored
      addv(1, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 2);
      addv(0, 1, 0, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 1, 1, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 1, 2, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 1, 3, 0, 1, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 1, 1, 1, 32'h1000,     0,  1, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            1,  1, 1, 32'h1000,     1, 0, 1);
      addv(0, 0, 0, 0, 1, 2, 0, 0,            2,  0, 0, 0,            1, 0, 2);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            1, 0, 2);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 2);
      // halt retires, then the machine freezes until reset
      addv(1, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 2);
      addv(0, 1, 0, 1, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 1, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            0,  1, 0, 0,            0, 0, 0);
      addv(0, 1, 1, 0, 1, 0, 0, 0,            1,  0, 0, 0,            1, 1, 1);
      addv(0, 0, 0, 0, 1, 1, 0, 0,            0,  0, 0, 0,            1, 1, 1);
      addv(1, 0, 0, 0, 0, 0, 0, 0,            0,  0, 0, 0,            1, 1, 1);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            0,  0, 0, 0,            0, 0, 0);
      // same-cycle dispatch and completion to slot 5: dispatch wins
      addv(0, 1, 5, 0, 1, 5, 0, 0,            5,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            5,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 1, 5, 0, 0,            5,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            5,  1, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            6,  0, 0, 0,            0, 0, 1);
      // wrap: slots 6,7,0,1 retire back to back
      addv(0, 1, 6, 0, 0, 0, 0, 0,            5,  0, 0, 0,            0, 0, 1);
      addv(0, 1, 7, 0, 1, 6, 0, 0,            5,  0, 0, 0,            0, 0, 1);
      addv(0, 1, 0, 0, 1, 7, 0, 0,            5,  0, 0, 0,            0, 0, 1);
      addv(0, 1, 1, 0, 1, 0, 0, 0,            5,  0, 0, 0,            0, 0, 1);
      addv(0, 0, 0, 0, 1, 1, 0, 0,            6,  1, 0, 0,            0, 0, 1);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            7,  1, 0, 0,            0, 0, 2);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            0,  1, 0, 0,            0, 0, 3);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            1,  1, 0, 0,            0, 0, 4);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 5);
      // reset in the middle of recovery
      addv(0, 1, 3, 0, 0, 0, 0, 0,            2,  0, 0, 0,            0, 0, 5);
      addv(0, 0, 0, 0, 1, 3, 1, 32'hCAFE0000, 2,  0, 0, 0,            0, 0, 5);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            3,  1, 1, 32'hCAFE0000, 1, 0, 5);
      addv(1, 0, 0, 0, 0, 0, 0, 0,            4,  0, 0, 0,            1, 0, 6);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            3,  0, 0, 0,            0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,            4,  0, 0, 0,            0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clock);
         #1;
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkOutput();
      end

      // Recovery window length: dispatch_stall spans the undo cycle plus
      // RECOVER_CYCLES, with exactly one undo pulse inside a fixed window.
      @(posedge clock);
      #1;
      reset               = 1'b0;
      dispatch_valid      = 1'b1;
      dispatch_index      = 3'd0;
      dispatch_is_halt    = 1'b0;
      complete_valid      = 1'b0;
      rob_head            = 3'd0;
      @(posedge clock);
      #1;
      dispatch_valid      = 1'b0;
      complete_valid      = 1'b1;
      complete_index      = 3'd0;
      complete_mispredict = 1'b1;
      complete_target     = 32'h0000_2000;
      @(posedge clock);
      #1;
      complete_valid      = 1'b0;
      complete_mispredict = 1'b0;
      stall_cnt = 0;
      undo_cnt  = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (dispatch_stall) stall_cnt++;
         if (undo) begin
            undo_cnt++;
            checkField("recover_squash_pc", squash_pc, 32'h0000_2000);
         end
         @(posedge clock);
         #1;
      end
      checkField("recover_stall_len", 32'(stall_cnt), 32'(1 + RECOVER_CYCLES));
      checkField("recover_undo_pulses", 32'(undo_cnt), 32'd1);
      checkField("recover_retired_count", retired_count, 32'd1);
      n_vec++;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Commit-side controller for the reorder buffer. Tracks per-entry completion state for every ROB slot, decides each cycle whether the head entry may retire, and drives the ROB's `move_head` / `undo` controls. On a mispredicted branch reaching the head it squashes younger work and runs a fixed-length recovery sequence; on a halt it freezes the machine. Sits between dispatch, the completion broadcast (CDB) and the `reorder_buffer`.

## Interface
- `ROB_SZ`, default 8: number of ROB entries, a power of two ≥ 2. `IDX = $clog2(ROB_SZ)`.
- `RECOVER_CYCLES`, default 2: stall cycles after a squash, ≥ 1.
- `XLEN`, default 32: PC width.

Ports (clock and reset first):
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dispatch_valid` in 1: an instruction enters the ROB this cycle.
- `dispatch_index` in IDX: ROB slot written (the ROB's `inst_index`).
- `dispatch_is_halt` in 1: the dispatched instruction is a halt.
- `complete_valid` in 1: completion broadcast this cycle.
- `complete_index` in IDX: ROB slot that completed.
- `complete_mispredict` in 1: the completing branch was mispredicted.
- `complete_target` in XLEN: correct PC for a mispredict.
- `rob_head` in IDX: current ROB head.
- `move_head` out 1: retire the head entry this cycle.
- `retire_index` out IDX: equals `rob_head`.
- `undo` out 1: squash pulse to the ROB.
- `undo_index` out IDX: equals `rob_head`; the mispredicted branch is the last surviving entry.
- `squash_pc` out XLEN: fetch redirect target, valid when `undo` = 1.
- `dispatch_stall` out 1: dispatch must not present instructions.
- `halt` out 1: sticky; the machine has halted.
- `retired_count` out 32: number of retired instructions, wraps modulo 2^32.

## Operation
- Per-slot registers: `valid`, `done`, `mispred`, `is_halt`, `target[XLEN]`.
- Dispatch (accepted in RUN only):
  - sets `valid` = 1 and `is_halt` = `dispatch_is_halt`;
  - clears `done` and `mispred`;
  - overwrites the slot unconditionally.
- Completion (any state except HALTED), when the slot has `valid` = 1:
  - sets `done` = 1, `mispred` = `complete_mispredict`, `target` = `complete_target`;
  - completion to a slot with `valid` = 0 is ignored.
- If dispatch and completion hit the same index in the same cycle, dispatch wins and the completion is dropped.
- FSM states: RUN, RECOVER, HALTED.
- RUN, when `H` = `valid[rob_head]` & `done[rob_head]`:
  - `H` & `mispred`: `move_head` = 1, `undo` = 1, `squash_pc` = `target`, `dispatch_stall` = 1. All `valid` bits clear at the edge, the counter loads `RECOVER_CYCLES`, and the FSM goes to RECOVER.
  - `H` & `is_halt` (checked when `mispred` = 0): `move_head` = 1 and the FSM goes to HALTED.
  - `H` otherwise: `move_head` = 1, and `valid[rob_head]` clears at the edge.
  - `!H`: all commit outputs are 0.
- Whenever `move_head` = 1, `retired_count` increments.
- RECOVER:
  - `dispatch_stall` = 1, `move_head` = 0, `undo` = 0;
  - the counter decrements each cycle; the FSM returns to RUN in the cycle after the counter reaches 1.
- HALTED: `halt` = 1 and `dispatch_stall` = 1. All other commit outputs are 0, and there is no exit except reset.
- At most one retire per cycle.

## Timing
- `move_head`, `undo`, `squash_pc` and `retire_index` are combinational from registered state plus `rob_head`. They must not depend combinationally on the `complete_*` or `dispatch_*` inputs.
- Completion-to-retire latency is 1 cycle minimum: completion in cycle t, `move_head` no earlier than cycle t+1.
- `undo` is a single-cycle pulse. `dispatch_stall` is high for 1 + `RECOVER_CYCLES` cycles starting at the `undo` cycle.
- `halt` rises in the cycle after the halt instruction retires.
- Reset (takes effect at the edge, including mid-RECOVER and in HALTED):
  - all `valid`, `done`, `mispred` and `is_halt` bits 0; state RUN; counter 0; `retired_count` 0;
  - all outputs 0 except `retire_index` and `undo_index`, which follow `rob_head`.
- Wrap-around: indices are IDX bits wide; head and dispatch index wrap modulo `ROB_SZ` with no special case.

## Test plan
- Reset, then dispatch slots 0–2 and complete slot 1, then slot 0 → cycle after slot 0 completes, `move_head` = 1 with `rob_head` = 0. With the bench advancing head, slot 1 retires the next cycle; slot 2 does not retire. `retired_count` = 2.
- Dispatch slots 0–3; slot 1 completes with `complete_mispredict` = 1 and `target` = 0x1000. Retire slot 0, then present `rob_head` = 1 → `undo` = 1, `undo_index` = 1, `squash_pc` = 0x1000. `dispatch_stall` is high for 3 cycles (`RECOVER_CYCLES` = 2). A completion arriving for slot 2 during RECOVER is ignored.
- Halt dispatched to slot 0 and completed → `move_head` pulse, then `halt` = 1 and `dispatch_stall` = 1 sticky. Further completions and dispatches cause no `move_head`. Reset returns the block to RUN with all outputs 0.
- Same-cycle dispatch and completion to slot 5 (`ROB_SZ` = 8) → slot is `valid` = 1, `done` = 0, and no retire when head = 5.
- Wrap: fill slots 6, 7, 0, 1, complete all, head walks 6→7→0→1 → 4 consecutive `move_head` cycles; `retired_count` increments by 4.
- Reset asserted mid-RECOVER → next cycle state is RUN, `dispatch_stall` = 0, and all slots are invalid.
